// File: rtl/or1200_imem_arb_if.sv
// Bus bundle shared by the instruction-memory arbiter and its environment.
// "slave" is the arbiter's view (it serves the CPU and debug requesters and
// drives the shared instruction port); "master" is the view of everything
// around it: requesters, the memory side, and a testbench.
interface or1200_imem_arb_if;
    // CPU fetch side
    logic        c_req;
    logic [31:0] c_adr;
    logic        c_flush;
    logic        c_ack;
    logic        c_err;
    logic [31:0] c_dat;
    logic [3:0]  c_tag;

    // Debug-unit read side
    logic        d_req;
    logic [31:0] d_adr;
    logic        d_ack;
    logic        d_err;
    logic [31:0] d_dat;

    // Shared instruction port
    logic        m_req;
    logic [31:0] m_adr;
    logic        m_ack;
    logic        m_err;
    logic [31:0] m_dat;
    logic [3:0]  m_tag;

    modport master (
        output c_req, c_adr, c_flush, d_req, d_adr,
               m_ack, m_err, m_dat, m_tag,
        input  c_ack, c_err, c_dat, c_tag, d_ack, d_err, d_dat,
               m_req, m_adr
    );

    modport slave (
        input  c_req, c_adr, c_flush, d_req, d_adr,
               m_ack, m_err, m_dat, m_tag,
        output c_ack, c_err, c_dat, c_tag, d_ack, d_err, d_dat,
               m_req, m_adr
    );
endinterface

// File: rtl/or1200_imem_arb.sv
// Instruction-memory arbiter: shares one instruction port between CPU fetches
// and debug-unit reads. One transaction outstanding at most, round-robin on
// ties, combinational return path, flush handling via a DRAIN state that
// swallows the orphaned response, and a watchdog that forces a bus error if
// the memory never answers.
module or1200_imem_arb #(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic              clk,
    input  logic              rst,
    or1200_imem_arb_if.slave  bus,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_C = 2'd1,
        GNT_D = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [7:0]  wait_cnt;
    logic        last_grant_d;
    logic [31:0] m_adr_q;

    logic        c_elig;
    logic        d_elig;
    logic        pick_c;
    logic        pick_d;
    logic        resp;
    logic        expired;

    logic        c_ack;
    logic        c_err;
    logic [31:0] c_dat;
    logic [3:0]  c_tag;
    logic        d_ack;
    logic        d_err;
    logic [31:0] d_dat;

    // State register; reset forgets any in-flight transaction outright.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Arbitration, response routing, flush and watchdog decisions.
    // m_err takes priority over m_ack so the CPU never sees both at once.
    always_comb begin
        state_next = state;
        pick_c     = 1'b0;
        pick_d     = 1'b0;
        c_ack      = 1'b0;
        c_err      = 1'b0;
        c_dat      = 32'h0;
        c_tag      = 4'h0;
        d_ack      = 1'b0;
        d_err      = 1'b0;
        d_dat      = 32'h0;
        c_elig     = bus.c_req & ~bus.c_flush;
        d_elig     = bus.d_req;
        resp       = bus.m_ack | bus.m_err;
        expired    = (wait_cnt == TIMEOUT);

        case (state)
            IDLE: begin
                if (c_elig && d_elig) begin
                    pick_c = last_grant_d;
                    pick_d = ~last_grant_d;
                end else begin
                    pick_c = c_elig;
                    pick_d = d_elig;
                end
                if (pick_c) begin
                    state_next = GNT_C;
                end else if (pick_d) begin
                    state_next = GNT_D;
                end
            end
            GNT_C: begin
                if (resp) begin
                    state_next = IDLE;
                    if (!bus.c_flush) begin
                        c_err = bus.m_err;
                        c_ack = bus.m_ack & ~bus.m_err;
                        c_dat = bus.m_dat;
                        c_tag = bus.m_tag;
                    end
                end else if (bus.c_flush) begin
                    state_next = DRAIN;
                end else if (expired) begin
                    state_next = IDLE;
                    c_err      = 1'b1;
                    c_tag      = 4'hb;
                end
            end
            GNT_D: begin
                if (resp) begin
                    state_next = IDLE;
                    d_err      = bus.m_err;
                    d_ack      = bus.m_ack & ~bus.m_err;
                    d_dat      = bus.m_dat;
                end else if (expired) begin
                    state_next = IDLE;
                    d_err      = 1'b1;
                end
            end
            DRAIN: begin
                if (resp || expired) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Address latch, tie-break history and the saturating wait counter.
    // The counter restarts whenever the state changes, so entering DRAIN
    // gives the orphaned access a fresh timeout window.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_adr_q      <= 32'h0;
            last_grant_d <= 1'b1;
            wait_cnt     <= 8'h0;
        end else begin
            if (pick_c) begin
                m_adr_q      <= bus.c_adr & 32'hffff_fffc;
                last_grant_d <= 1'b0;
            end else if (pick_d) begin
                m_adr_q      <= bus.d_adr & 32'hffff_fffc;
                last_grant_d <= 1'b1;
            end
            if (state_next != state) begin
                wait_cnt <= 8'h0;
            end else if (state != IDLE && !expired) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end

    assign busy      = (state != IDLE);
    assign bus.m_req = (state != IDLE);
    assign bus.m_adr = m_adr_q;
    assign bus.c_ack = c_ack;
    assign bus.c_err = c_err;
    assign bus.c_dat = c_dat;
    assign bus.c_tag = c_tag;
    assign bus.d_ack = d_ack;
    assign bus.d_err = d_err;
    assign bus.d_dat = d_dat;

endmodule

// File: tb/tb_or1200_imem_arb.sv
// Directed bench for or1200_imem_arb (TIMEOUT=4). Inputs change 1 time unit
// after the rising edge; outputs are checked on the falling edge.
module tb_or1200_imem_arb;

    logic clk;
    logic rst;
    logic busy;

    int vectors;
    int miscompares;

    or1200_imem_arb_if bus ();

    or1200_imem_arb #(.TIMEOUT(8'd4)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got running want finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.c_req   = 1'b0;
        bus.c_adr   = 32'h0;
        bus.c_flush = 1'b0;
        bus.d_req   = 1'b0;
        bus.d_adr   = 32'h0;
        bus.m_ack   = 1'b0;
        bus.m_err   = 1'b0;
        bus.m_dat   = 32'h0;
        bus.m_tag   = 4'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        step();
        step();
        @(negedge clk);
        if ({busy, bus.m_req, bus.m_adr} !== {1'b0, 1'b0, 32'h0}) begin
            $display("[TB] FAIL reset_port: got busy=%b m_req=%b m_adr=%h want 0 0 00000000",
                     busy, bus.m_req, bus.m_adr);
            miscompares++;
        end
        vectors++;
        if ({bus.c_ack, bus.c_err, bus.d_ack, bus.d_err, bus.c_dat, bus.c_tag, bus.d_dat} !== 72'h0) begin
            $display("[TB] FAIL reset_completions: got c_ack=%b c_err=%b d_ack=%b d_err=%b want all 0",
                     bus.c_ack, bus.c_err, bus.d_ack, bus.d_err);
            miscompares++;
        end
        vectors++;
        step();
        rst = 1'b0;
    endtask

    task automatic test_cpu_fetch();
        bus.c_req = 1'b1;
        bus.c_adr = 32'h0000_2003;
        step();
        @(negedge clk);
        if ({bus.m_req, bus.m_adr, bus.c_ack} !== {1'b1, 32'h0000_2000, 1'b0}) begin
            $display("[TB] FAIL fetch_grant: got m_req=%b m_adr=%h c_ack=%b want 1 00002000 0",
                     bus.m_req, bus.m_adr, bus.c_ack);
            miscompares++;
        end
        vectors++;
        step();
        step();
        step();
        bus.m_ack = 1'b1;
        bus.m_dat = 32'h1500_0000;
        @(negedge clk);
        if ({bus.c_ack, bus.c_err, bus.c_dat, bus.m_req} !== {1'b1, 1'b0, 32'h1500_0000, 1'b1}) begin
            $display("[TB] FAIL fetch_ack: got c_ack=%b c_err=%b c_dat=%h m_req=%b want 1 0 15000000 1",
                     bus.c_ack, bus.c_err, bus.c_dat, bus.m_req);
            miscompares++;
        end
        vectors++;
        step();
        bus.m_ack = 1'b0;
        bus.c_req = 1'b0;
        @(negedge clk);
        if ({busy, bus.m_req, bus.c_ack, bus.c_dat} !== {1'b0, 1'b0, 1'b0, 32'h0}) begin
            $display("[TB] FAIL fetch_idle: got busy=%b m_req=%b c_ack=%b c_dat=%h want 0 0 0 00000000",
                     busy, bus.m_req, bus.c_ack, bus.c_dat);
            miscompares++;
        end
        vectors++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_adr [4];
        logic        exp_c   [4];
        exp_adr[0] = 32'h0000_1000; exp_c[0] = 1'b1;
        exp_adr[1] = 32'h8000_0004; exp_c[1] = 1'b0;
        exp_adr[2] = 32'h0000_1000; exp_c[2] = 1'b1;
        exp_adr[3] = 32'h8000_0004; exp_c[3] = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.c_req = 1'b1;
        bus.c_adr = 32'h0000_1001;
        bus.d_req = 1'b1;
        bus.d_adr = 32'h8000_0006;
        for (int i = 0; i < 4; i++) begin
            step();
            bus.m_ack = 1'b1;
            bus.m_dat = 32'hc0de_0000 + 32'(i);
            @(negedge clk);
            if ({bus.m_adr, bus.c_ack, bus.d_ack} !== {exp_adr[i], exp_c[i], ~exp_c[i]}) begin
                $display("[TB] FAIL rr_grant%0d: got m_adr=%h c_ack=%b d_ack=%b want %h %b %b",
                         i, bus.m_adr, bus.c_ack, bus.d_ack, exp_adr[i], exp_c[i], ~exp_c[i]);
                miscompares++;
            end
            vectors++;
            if ((exp_c[i] ? bus.c_dat : bus.d_dat) !== 32'hc0de_0000 + 32'(i)) begin
                $display("[TB] FAIL rr_data%0d: got c_dat=%h d_dat=%h want %h on granted side",
                         i, bus.c_dat, bus.d_dat, 32'hc0de_0000 + 32'(i));
                miscompares++;
            end
            vectors++;
            step();
            bus.m_ack = 1'b0;
            @(negedge clk);
            if ({busy, bus.c_ack, bus.d_ack} !== 3'b000) begin
                $display("[TB] FAIL rr_gap%0d: got busy=%b c_ack=%b d_ack=%b want 0 0 0",
                         i, busy, bus.c_ack, bus.d_ack);
                miscompares++;
            end
            vectors++;
        end
        idle_inputs();
        step();
    endtask

    task automatic test_flush_drain();
        bus.c_req = 1'b1;
        bus.c_adr = 32'h0000_3000;
        step();
        step();
        bus.c_flush = 1'b1;
        bus.c_req   = 1'b0;
        @(negedge clk);
        if ({bus.m_req, bus.c_ack} !== 2'b10) begin
            $display("[TB] FAIL flush_cycle: got m_req=%b c_ack=%b want 1 0", bus.m_req, bus.c_ack);
            miscompares++;
        end
        vectors++;
        step();
        bus.c_flush = 1'b0;
        @(negedge clk);
        if ({busy, bus.m_req, bus.m_adr} !== {1'b1, 1'b1, 32'h0000_3000}) begin
            $display("[TB] FAIL drain_hold: got busy=%b m_req=%b m_adr=%h want 1 1 00003000",
                     busy, bus.m_req, bus.m_adr);
            miscompares++;
        end
        vectors++;
        step();
        bus.m_ack = 1'b1;
        bus.m_dat = 32'hdead_beef;
        @(negedge clk);
        if ({bus.m_req, bus.c_ack, bus.c_err, bus.c_dat} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
            $display("[TB] FAIL drain_ack: got m_req=%b c_ack=%b c_err=%b c_dat=%h want 1 0 0 00000000",
                     bus.m_req, bus.c_ack, bus.c_err, bus.c_dat);
            miscompares++;
        end
        vectors++;
        step();
        bus.m_ack = 1'b0;
        @(negedge clk);
        if (busy !== 1'b0) begin
            $display("[TB] FAIL drain_done: got busy=%b want 0", busy);
            miscompares++;
        end
        vectors++;
    endtask

    task automatic test_flush_with_ack();
        bus.c_req = 1'b1;
        bus.c_adr = 32'h0000_4000;
        step();
        bus.c_flush = 1'b1;
        bus.m_ack   = 1'b1;
        bus.m_dat   = 32'h1234_5678;
        @(negedge clk);
        if ({bus.c_ack, bus.c_err, bus.c_dat} !== {1'b0, 1'b0, 32'h0}) begin
            $display("[TB] FAIL flush_ack_suppress: got c_ack=%b c_err=%b c_dat=%h want 0 0 00000000",
                     bus.c_ack, bus.c_err, bus.c_dat);
            miscompares++;
        end
        vectors++;
        step();
        idle_inputs();
        @(negedge clk);
        if (busy !== 1'b0) begin
            $display("[TB] FAIL flush_ack_idle: got busy=%b want 0", busy);
            miscompares++;
        end
        vectors++;
    endtask

    task automatic test_debug_timeout();
        bus.d_req = 1'b1;
        bus.d_adr = 32'h0000_0044;
        for (int i = 0; i < 5; i++) begin
            step();
            bus.c_flush = (i == 1);
            @(negedge clk);
            if ({bus.m_req, bus.d_err, bus.d_ack} !== {1'b1, (i == 4), 1'b0}) begin
                $display("[TB] FAIL dbg_timeout%0d: got m_req=%b d_err=%b d_ack=%b want 1 %b 0",
                         i, bus.m_req, bus.d_err, bus.d_ack, (i == 4));
                miscompares++;
            end
            vectors++;
        end
        step();
        idle_inputs();
        @(negedge clk);
        if ({busy, bus.m_req, bus.d_err} !== 3'b000) begin
            $display("[TB] FAIL dbg_timeout_idle: got busy=%b m_req=%b d_err=%b want 0 0 0",
                     busy, bus.m_req, bus.d_err);
            miscompares++;
        end
        vectors++;
    endtask

    task automatic test_cpu_timeout();
        bus.c_req = 1'b1;
        bus.c_adr = 32'h0000_6000;
        for (int i = 0; i < 5; i++) begin
            step();
            @(negedge clk);
            if ({bus.c_err, bus.c_tag} !== {(i == 4), (i == 4) ? 4'hb : 4'h0}) begin
                $display("[TB] FAIL cpu_timeout%0d: got c_err=%b c_tag=%h want %b %h",
                         i, bus.c_err, bus.c_tag, (i == 4), (i == 4) ? 4'hb : 4'h0);
                miscompares++;
            end
            vectors++;
        end
        step();
        idle_inputs();
        @(negedge clk);
        if (bus.m_req !== 1'b0) begin
            $display("[TB] FAIL cpu_timeout_idle: got m_req=%b want 0", bus.m_req);
            miscompares++;
        end
        vectors++;
    endtask

    task automatic test_error_tag();
        bus.c_req = 1'b1;
        bus.c_adr = 32'h0000_7008;
        step();
        step();
        bus.m_err = 1'b1;
        bus.m_tag = 4'hd;
        @(negedge clk);
        if ({bus.c_err, bus.c_ack, bus.c_tag, bus.d_err} !== {1'b1, 1'b0, 4'hd, 1'b0}) begin
            $display("[TB] FAIL err_tag: got c_err=%b c_ack=%b c_tag=%h d_err=%b want 1 0 d 0",
                     bus.c_err, bus.c_ack, bus.c_tag, bus.d_err);
            miscompares++;
        end
        vectors++;
        step();
        idle_inputs();
        @(negedge clk);
        if ({busy, bus.c_err, bus.c_tag} !== {1'b0, 1'b0, 4'h0}) begin
            $display("[TB] FAIL err_tag_idle: got busy=%b c_err=%b c_tag=%h want 0 0 0",
                     busy, bus.c_err, bus.c_tag);
            miscompares++;
        end
        vectors++;
    endtask

    task automatic test_stray_ack();
        bus.m_ack = 1'b1;
        bus.m_err = 1'b1;
        bus.m_dat = 32'hffff_ffff;
        @(negedge clk);
        if ({bus.c_ack, bus.c_err, bus.d_ack, bus.d_err, bus.c_dat, bus.d_dat} !== 68'h0) begin
            $display("[TB] FAIL stray_ack: got c_ack=%b c_err=%b d_ack=%b d_err=%b want all 0",
                     bus.c_ack, bus.c_err, bus.d_ack, bus.d_err);
            miscompares++;
        end
        vectors++;
        step();
        @(negedge clk);
        if (busy !== 1'b0) begin
            $display("[TB] FAIL stray_ack_busy: got busy=%b want 0", busy);
            miscompares++;
        end
        vectors++;
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        bus.c_req = 1'b1;
        bus.c_adr = 32'h0000_5000;
        step();
        @(negedge clk);
        if (busy !== 1'b1) begin
            $display("[TB] FAIL rstmid_grant: got busy=%b want 1", busy);
            miscompares++;
        end
        vectors++;
        step();
        rst = 1'b1;
        step();
        rst       = 1'b0;
        bus.c_req = 1'b0;
        bus.m_ack = 1'b1;
        bus.m_dat = 32'haaaa_5555;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if ({busy, bus.m_req, bus.c_ack, bus.c_err, bus.d_ack} !== 5'b0) begin
                $display("[TB] FAIL rstmid_quiet%0d: got busy=%b m_req=%b c_ack=%b c_err=%b d_ack=%b want all 0",
                         i, busy, bus.m_req, bus.c_ack, bus.c_err, bus.d_ack);
                miscompares++;
            end
            vectors++;
            step();
        end
        idle_inputs();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        idle_inputs();
        test_reset();
        test_cpu_fetch();
        test_back_to_back();
        test_flush_drain();
        test_flush_with_ack();
        test_debug_timeout();
        test_cpu_timeout();
        test_error_tag();
        test_stray_ack();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
